// File: rtl/addr8s_check_stage_if.sv
// Operand, adder-pin and result bundle for the addr8s check stage.
// slave = stage side, master = producer/adder/consumer side.
interface addr8s_check_stage_if #(
  parameter int ERR_CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_a;
  logic [7:0]           in_b;
  logic [7:0]           add_a;
  logic [7:0]           add_b;
  logic [8:0]           add_o;
  logic                 out_valid;
  logic                 out_ready;
  logic [8:0]           out_sum;
  logic                 out_fault;
  logic [ERR_CNT_W-1:0] err_count;

  modport slave (
    input  in_valid, in_a, in_b, add_o, out_ready,
    output in_ready, add_a, add_b, out_valid,
    output out_sum, out_fault, err_count
  );

  modport master (
    output in_valid, in_a, in_b, add_o, out_ready,
    input  in_ready, add_a, add_b, out_valid,
    input  out_sum, out_fault, err_count
  );
endinterface

// File: rtl/addr8s_check_stage.sv
// Capture-and-check stage for the 8-bit signed adders: drive, settle,
// sample, retry on mismatch, report sum plus fault flag.
module addr8s_check_stage #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 2,
  parameter int ERR_CNT_W     = 16
) (
  input logic             clk,
  input logic             rst,
  addr8s_check_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    OUT
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           add_a_q, add_a_d;
  logic [7:0]           add_b_q, add_b_d;
  logic [8:0]           gold_q, gold_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           rty_q, rty_d;
  logic                 out_valid_q, out_valid_d;
  logic [8:0]           out_sum_q, out_sum_d;
  logic                 out_fault_q, out_fault_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] RtyMax  = 3'(MAX_RETRY);

  always_comb begin
    state_d     = state_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    gold_d      = gold_q;
    cnt_d       = cnt_q;
    rty_d       = rty_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_fault_d = out_fault_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          add_a_d = bus.in_a;
          add_b_d = bus.in_b;
          gold_d  = {bus.in_a[7], bus.in_a}
                  + {bus.in_b[7], bus.in_b};
          cnt_d   = CntLoad;
          rty_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - 4'd1;
      end
      CHECK: begin
        if (bus.add_o == gold_q) begin
          out_sum_d   = bus.add_o;
          out_fault_d = 1'b0;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          // Counter sticks at all ones instead of wrapping
          if (err_q != '1) err_d = err_q + 1'b1;
          if (rty_q < RtyMax) begin
            rty_d   = rty_q + 3'd1;
            cnt_d   = CntLoad;
            state_d = SETTLE;
          end else begin
            out_sum_d   = gold_q;
            out_fault_d = 1'b1;
            out_valid_d = 1'b1;
            state_d     = OUT;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      add_a_q     <= '0;
      add_b_q     <= '0;
      gold_q      <= '0;
      cnt_q       <= '0;
      rty_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_fault_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      gold_q      <= gold_d;
      cnt_q       <= cnt_d;
      rty_q       <= rty_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_fault_q <= out_fault_d;
      err_q       <= err_d;
    end
  end

  // in_ready drops with rst itself, not just on the next edge
  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_fault = out_fault_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_addr8s_check_stage.sv
// Scoreboard bench: driver pushes expected results, monitor pops on out_valid.
// A second 4-bit-counter instance with a permanently broken adder checks saturation.
module tb_addr8s_check_stage;
  localparam int S = 2;
  localparam int R = 2;

  typedef struct {
    logic [8:0] sum;
    logic       fault;
    int         lat;
    int         err;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   k = 100;
  int   cur_mode = 0;
  int   mode_in = 0;
  int   exp_err = 0;
  bit   rand_or = 1'b0;
  bit   or_fixed = 1'b1;
  bit   seen = 1'b0;
  exp_t q[$];
  exp_t cur;

  addr8s_check_stage_if #(.ERR_CNT_W(16)) bus ();
  addr8s_check_stage_if #(.ERR_CNT_W(4))  bus2 ();

  addr8s_check_stage #(
    .SETTLE_CYCLES(S), .MAX_RETRY(R), .ERR_CNT_W(16)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  addr8s_check_stage #(
    .SETTLE_CYCLES(S), .MAX_RETRY(R), .ERR_CNT_W(4)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder model with injectable faults: 1 = bit0 stuck at 0, 2 = first sample wrong
  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      cur_mode <= mode_in;
      k <= 0;
    end else begin
      k <= k + 1;
    end
  end

  always_comb begin
    logic [8:0] s;
    s = {bus.add_a[7], bus.add_a} + {bus.add_b[7], bus.add_b};
    if (cur_mode == 1) s[0] = 1'b0;
    if (cur_mode == 2 && k <= S) s = s ^ 9'h001;
    bus.add_o = s;
  end

  assign bus2.add_o = ~({bus2.add_a[7], bus2.add_a}
                       + {bus2.add_b[7], bus2.add_b});

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      bus.out_ready = rand_or ? 1'($urandom_range(0, 1)) : or_fixed;
    end
  end

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (!seen) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid: got out_valid=1 expected 0");
        end else begin
          cur = q.pop_front();
          seen = 1'b1;
          chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
          chk("fault", 64'(bus.out_fault), 64'(cur.fault));
          chk("err_count", 64'(bus.err_count), 64'(cur.err));
        end
      end
      if (seen) begin
        chk("sum", 64'(bus.out_sum), 64'(cur.sum));
        chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
      end
    end else begin
      seen = 1'b0;
    end
  end

  // Called at a negedge; returns one negedge after the accept edge
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input int mode);
    int n, ga, mis;
    exp_t e;
    bus.in_a = a;
    bus.in_b = b;
    mode_in = mode;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 64'd1, 64'd0);
    ga = int'($signed(a)) + int'($signed(b));
    e.sum = ga[8:0];
    if (mode == 1) mis = e.sum[0] ? R + 1 : 0;
    else if (mode == 2) mis = 1;
    else mis = 0;
    e.fault = mis > R;
    e.lat = (S + 1) * (1 + (mis > R ? R : mis));
    exp_err = exp_err + mis > 65535 ? 65535 : exp_err + mis;
    e.err = exp_err;
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n, ga;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus2.in_valid = 1'b0;
    bus2.in_a = '0;
    bus2.in_b = '0;
    bus2.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_add_a", 64'(bus.add_a), 64'd0);
    chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_err", 64'(bus.err_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    send(8'h7F, 8'h01, 0);
    send(8'h80, 8'h80, 0);
    send(8'h05, 8'hFD, 0);
    send(8'h00, 8'h01, 1);
    send(8'h10, 8'h20, 2);
    drain();

    or_fixed = 1'b0;
    @(negedge clk);
    send(8'h33, 8'hC4, 0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("bp_valid_held", 64'(bus.out_valid), 64'd1);
    or_fixed = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idle", 64'(bus.in_ready), 64'd1);
    chk("bp_release_valid", 64'(bus.out_valid), 64'd0);

    bus.in_a = 8'h11;
    bus.in_b = 8'h22;
    mode_in = 0;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_add_a", 64'(bus.add_a), 64'd0);
    chk("mid_rst_err", 64'(bus.err_count), 64'd0);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
    repeat (10) @(negedge clk);

    rand_or = 1'b1;
    for (int i = 0; i < 40; i++)
      send(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    rand_or = 1'b0;
    drain();

    for (int i = 0; i < 6; i++) begin
      bus2.in_a = 8'($urandom);
      bus2.in_b = 8'($urandom);
      bus2.in_valid = 1'b1;
      n = 0;
      while (!bus2.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      bus2.in_valid = 1'b0;
      n = 0;
      while (!bus2.out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      ga = int'($signed(bus2.in_a)) + int'($signed(bus2.in_b));
      chk("sat_valid", 64'(bus2.out_valid), 64'd1);
      chk("sat_err", 64'(bus2.err_count),
          64'((3 * (i + 1)) > 15 ? 15 : 3 * (i + 1)));
      chk("sat_fault", 64'(bus2.out_fault), 64'd1);
      chk("sat_sum", 64'(bus2.out_sum), 64'(ga[8:0]));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
